// File: rtl/wb_ic_pkg.sv
// -----------------------------------------------------------------------------
// wb_ic_pkg
// Shared types and defaults for the Wishbone peripheral interconnect:
//   - state_e      : interconnect FSM state encoding
//   - *_DEF        : default parameter values for the top level
//   - idx_width()  : clog2-based width helper (never returns 0)
// -----------------------------------------------------------------------------
package wb_ic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } state_e;

    localparam int unsigned WB_NUM_SLAVES_DEF     = 4;
    localparam int unsigned WB_ADDR_WIDTH_DEF     = 32;
    localparam int unsigned WB_DATA_WIDTH_DEF     = 32;
    localparam int unsigned WB_SEL_BITS_DEF       = 8;
    localparam int unsigned WB_TIMEOUT_CYCLES_DEF = 256;

    // Bits needed to index n items; at least 1 so a single-item index is legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wb_ic_timeout.sv
// -----------------------------------------------------------------------------
// wb_ic_timeout
// Counts cycles while enabled and flags the cycle in which the count reaches
// TIMEOUT_CYCLES. Built only when WB_TIMEOUT_EN is defined.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   en         : count this cycle
//   clr        : clear the counter (wins over en)
//   expire_c   : combinational, high during the TIMEOUT_CYCLES-th enabled cycle
// -----------------------------------------------------------------------------
module wb_ic_timeout
    import wb_ic_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire_c
);

    localparam int unsigned CNT_W = idx_width(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts completed cycles, so the last allowed cycle sees TIMEOUT_CYCLES-1.
    assign expire_c = en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_periph_interconnect.sv
// -----------------------------------------------------------------------------
// wb_periph_interconnect
// Single-master to NUM_SLAVES Wishbone peripheral interconnect. The top
// SEL_BITS of the address select a slave; the remaining bits are forwarded as
// the slave offset. Unmapped indices complete with ack+err and zero data.
// Optional macro: WB_TIMEOUT_EN adds an ACTIVE-state watchdog (wb_ic_timeout).
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   i_m_cyc/stb/we/sel/adr/dat    : master request
//   o_m_dat/ack/err               : master response (registered)
//   o_m_int                       : registered OR of slave interrupts
//   o_s_cyc/o_s_stb               : one-hot per-slave cycle/strobe
//   o_s_we/sel/adr/dat            : shared slave request fields
//   i_s_dat/ack/int               : slave responses, data flattened per slave
// -----------------------------------------------------------------------------
module wb_periph_interconnect
    import wb_ic_pkg::*;
#(
    parameter int unsigned NUM_SLAVES     = WB_NUM_SLAVES_DEF,
    parameter int unsigned ADDR_WIDTH     = WB_ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH     = WB_DATA_WIDTH_DEF,
    parameter int unsigned SEL_BITS       = WB_SEL_BITS_DEF,
    parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_m_cyc,
    input  logic                             i_m_stb,
    input  logic                             i_m_we,
    input  logic [DATA_WIDTH/8-1:0]          i_m_sel,
    input  logic [ADDR_WIDTH-1:0]            i_m_adr,
    input  logic [DATA_WIDTH-1:0]            i_m_dat,
    output logic [DATA_WIDTH-1:0]            o_m_dat,
    output logic                             o_m_ack,
    output logic                             o_m_err,
    output logic                             o_m_int,
    output logic [NUM_SLAVES-1:0]            o_s_cyc,
    output logic [NUM_SLAVES-1:0]            o_s_stb,
    output logic                             o_s_we,
    output logic [DATA_WIDTH/8-1:0]          o_s_sel,
    output logic [ADDR_WIDTH-SEL_BITS-1:0]   o_s_adr,
    output logic [DATA_WIDTH-1:0]            o_s_dat,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_s_dat,
    input  logic [NUM_SLAVES-1:0]            i_s_ack,
    input  logic [NUM_SLAVES-1:0]            i_s_int
);

    localparam int unsigned SEL_W = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = ADDR_WIDTH - SEL_BITS;
    localparam int unsigned IDX_W = idx_width(NUM_SLAVES);

    // Reject parameter sets the datapath cannot represent.
    if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1 ||
        SEL_BITS < 1 || SEL_BITS >= ADDR_WIDTH || SEL_BITS > 31) begin : g_bad_param
        $error("wb_periph_interconnect: illegal parameter combination");
    end

    function automatic logic [NUM_SLAVES-1:0] onehot(input logic [IDX_W-1:0] i);
        return NUM_SLAVES'(1) << i;
    endfunction

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    we_q, we_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [OFF_W-1:0]        adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
    logic [NUM_SLAVES-1:0]   s_cyc_q, s_cyc_d;
    logic                    m_ack_q, m_ack_d;
    logic                    m_err_q, m_err_d;
    logic [DATA_WIDTH-1:0]   m_dat_q, m_dat_d;
    logic                    int_q, int_d;

    logic [SEL_BITS-1:0]     sel_idx_c;
    logic                    mapped_c;
    logic                    tmo_expire_c;

    assign sel_idx_c = i_m_adr[ADDR_WIDTH-1 -: SEL_BITS];
    // Compare the full index so an all-ones index can never alias onto a slave.
    assign mapped_c  = (32'(sel_idx_c) < NUM_SLAVES);

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        s_cyc_d = '0;
        m_ack_d = 1'b0;
        m_err_d = 1'b0;
        m_dat_d = m_dat_q;
        int_d   = |i_s_int;

        case (state_q)
            ST_IDLE: begin
                if (i_m_cyc && i_m_stb) begin
                    idx_d  = IDX_W'(sel_idx_c);
                    we_d   = i_m_we;
                    sel_d  = i_m_sel;
                    adr_d  = i_m_adr[OFF_W-1:0];
                    wdat_d = i_m_dat;
                    if (mapped_c) begin
                        state_d = ST_ACTIVE;
                        s_cyc_d = onehot(IDX_W'(sel_idx_c));
                    end else begin
                        state_d = ST_ERR;
                        m_ack_d = 1'b1;
                        m_err_d = 1'b1;
                        m_dat_d = '0;
                    end
                end
            end

            ST_ACTIVE: begin
                // Abort beats a same-cycle slave ack; timeout only when no ack.
                if (!i_m_cyc) begin
                    state_d = ST_IDLE;
                end else if (i_s_ack[idx_q]) begin
                    state_d = ST_DONE;
                    m_ack_d = 1'b1;
                    m_dat_d = i_s_dat[idx_q*DATA_WIDTH +: DATA_WIDTH];
                end else if (tmo_expire_c) begin
                    state_d = ST_ERR;
                    m_ack_d = 1'b1;
                    m_err_d = 1'b1;
                    m_dat_d = '0;
                end else begin
                    s_cyc_d = onehot(idx_q);
                end
            end

            // Response already issued; a held request must not restart.
            ST_DONE, ST_ERR: begin
                if (!i_m_cyc || !i_m_stb) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            s_cyc_q <= '0;
            m_ack_q <= 1'b0;
            m_err_q <= 1'b0;
            m_dat_q <= '0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            s_cyc_q <= s_cyc_d;
            m_ack_q <= m_ack_d;
            m_err_q <= m_err_d;
            m_dat_q <= m_dat_d;
            int_q   <= int_d;
        end
    end

`ifdef WB_TIMEOUT_EN
    logic tmo_en_c;
    logic tmo_clr_c;

    assign tmo_en_c  = (state_q == ST_ACTIVE);
    assign tmo_clr_c = (state_d != ST_ACTIVE);

    wb_ic_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .en       (tmo_en_c),
        .clr      (tmo_clr_c),
        .expire_c (tmo_expire_c)
    );
`else
    assign tmo_expire_c = 1'b0;
`endif

    assign o_m_dat = m_dat_q;
    assign o_m_ack = m_ack_q;
    assign o_m_err = m_err_q;
    assign o_m_int = int_q;
    assign o_s_cyc = s_cyc_q;
    assign o_s_stb = s_cyc_q;
    assign o_s_we  = we_q;
    assign o_s_sel = sel_q;
    assign o_s_adr = adr_q;
    assign o_s_dat = wdat_q;

endmodule

// File: tb/tb_wb_periph_interconnect.sv
// -----------------------------------------------------------------------------
// tb_wb_periph_interconnect
// Self-checking bench for wb_periph_interconnect (NUM_SLAVES=4,
// TIMEOUT_CYCLES=16). Honours WB_TIMEOUT_EN for the no-ack scenario.
// -----------------------------------------------------------------------------
module tb_wb_periph_interconnect;

    localparam int unsigned NS = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SB = 8;
    localparam int unsigned TO = 16;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned OW = AW - SB;

    logic              clk;
    logic              rst;
    logic              i_m_cyc, i_m_stb, i_m_we;
    logic [SW-1:0]     i_m_sel;
    logic [AW-1:0]     i_m_adr;
    logic [DW-1:0]     i_m_dat;
    logic [DW-1:0]     o_m_dat;
    logic              o_m_ack, o_m_err, o_m_int;
    logic [NS-1:0]     o_s_cyc, o_s_stb;
    logic              o_s_we;
    logic [SW-1:0]     o_s_sel;
    logic [OW-1:0]     o_s_adr;
    logic [DW-1:0]     o_s_dat;
    logic [NS*DW-1:0]  i_s_dat;
    logic [NS-1:0]     i_s_ack, i_s_int;

    wb_periph_interconnect #(
        .NUM_SLAVES     (NS),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .SEL_BITS       (SB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_m_cyc (i_m_cyc),
        .i_m_stb (i_m_stb),
        .i_m_we  (i_m_we),
        .i_m_sel (i_m_sel),
        .i_m_adr (i_m_adr),
        .i_m_dat (i_m_dat),
        .o_m_dat (o_m_dat),
        .o_m_ack (o_m_ack),
        .o_m_err (o_m_err),
        .o_m_int (o_m_int),
        .o_s_cyc (o_s_cyc),
        .o_s_stb (o_s_stb),
        .o_s_we  (o_s_we),
        .o_s_sel (o_s_sel),
        .o_s_adr (o_s_adr),
        .o_s_dat (o_s_dat),
        .i_s_dat (i_s_dat),
        .i_s_ack (i_s_ack),
        .i_s_int (i_s_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    typedef struct {
        int            idx;
        logic [OW-1:0] off;
        logic          we;
        logic [SW-1:0] sel;
        logic [DW-1:0] wdat;
        logic [DW-1:0] sdat;
        int            lat;
        int            hold;
        logic          exp_err;
        logic [DW-1:0] exp_dat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One master transaction with a behavioural slave; called at posedge+1.
    task automatic run_txn(input vec_t v, input string tag);
        logic [NS-1:0] exp_oh;
        int n_stb, n_ack, ack_drv, ack_seen, exp_ack_c;
        bit fields_done;
        n_stb = 0; n_ack = 0; ack_drv = -1; ack_seen = -1; fields_done = 0;
        exp_oh = v.exp_err ? '0 : (NS'(1) << v.idx);

        i_m_adr = {SB'(v.idx), v.off};
        i_m_we  = v.we;
        i_m_sel = v.sel;
        i_m_dat = v.wdat;
        for (int s = 0; s < int'(NS); s++) begin
            i_s_dat[s*DW +: DW] = $urandom;
        end
        if (!v.exp_err) i_s_dat[v.idx*DW +: DW] = v.sdat;
        i_m_cyc = 1'b1;
        i_m_stb = 1'b1;

        for (int c = 1; c <= v.lat + v.hold + 6; c++) begin
            tick();
            // Unselected slaves chatter with acks that must be ignored.
            i_s_ack = NS'($urandom) & ~exp_oh;
            if (o_s_stb != '0) begin
                n_stb++;
                if (!fields_done) begin
                    fields_done = 1;
                    chk({tag, ".stb"}, 64'(o_s_stb), 64'(exp_oh));
                    chk({tag, ".cyc"}, 64'(o_s_cyc), 64'(exp_oh));
                    chk({tag, ".adr"}, 64'(o_s_adr), 64'(v.off));
                    chk({tag, ".we"},  64'(o_s_we),  64'(v.we));
                    chk({tag, ".sel"}, 64'(o_s_sel), 64'(v.sel));
                    chk({tag, ".sdat"}, 64'(o_s_dat), 64'(v.wdat));
                end
            end
            if (o_m_ack) begin
                n_ack++;
                if (ack_seen < 0) begin
                    ack_seen  = c;
                    exp_ack_c = v.exp_err ? 1 : ack_drv + 1;
                    chk({tag, ".ack_cycle"}, 64'(c), 64'(exp_ack_c));
                    chk({tag, ".mdat"}, 64'(o_m_dat), 64'(v.exp_dat));
                    chk({tag, ".err"},  64'(o_m_err), 64'(v.exp_err));
                end
            end
            if (!v.exp_err && ack_drv < 0 && n_stb == v.lat && o_s_stb != '0) begin
                i_s_ack[v.idx] = 1'b1;
                ack_drv = c;
            end
            if (ack_seen >= 0 && c >= ack_seen + v.hold) begin
                i_m_cyc = 1'b0;
                i_m_stb = 1'b0;
            end
        end
        i_m_cyc = 1'b0;
        i_m_stb = 1'b0;
        i_s_ack = '0;
        chk({tag, ".n_ack"}, 64'(n_ack), 64'd1);
        chk({tag, ".n_stb"}, 64'(n_stb), 64'(v.exp_err ? 0 : v.lat));
        tick();
    endtask

    initial begin
        vec_t tbl[7];
        vec_t rv;
        logic [NS-1:0] prev_int;
        int n_stb, err_at, bad, n_ack;

        checks = 0;
        failures = 0;

        tbl[0] = '{idx:2,   off:24'h000010, we:1'b0, sel:4'hF, wdat:32'h0,        sdat:32'hDEADBEEF, lat:3, hold:1, exp_err:1'b0, exp_dat:32'hDEADBEEF};
        tbl[1] = '{idx:1,   off:24'h000004, we:1'b1, sel:4'hF, wdat:32'h12345678, sdat:32'h0,        lat:1, hold:0, exp_err:1'b0, exp_dat:32'h0};
        tbl[2] = '{idx:7,   off:24'h000000, we:1'b0, sel:4'hF, wdat:32'h0,        sdat:32'h0,        lat:1, hold:2, exp_err:1'b1, exp_dat:32'h0};
        tbl[3] = '{idx:255, off:24'hFFFFFF, we:1'b1, sel:4'h3, wdat:32'h55AA55AA, sdat:32'h0,        lat:1, hold:3, exp_err:1'b1, exp_dat:32'h0};
        tbl[4] = '{idx:0,   off:24'h000000, we:1'b0, sel:4'h1, wdat:32'h0,        sdat:32'hA5A5A5A5, lat:1, hold:0, exp_err:1'b0, exp_dat:32'hA5A5A5A5};
        tbl[5] = '{idx:3,   off:24'hFFFFFF, we:1'b1, sel:4'hC, wdat:32'hCAFEF00D, sdat:32'h0F0F0F0F, lat:5, hold:3, exp_err:1'b0, exp_dat:32'h0F0F0F0F};
        tbl[6] = '{idx:4,   off:24'h123456, we:1'b0, sel:4'hF, wdat:32'h0,        sdat:32'h0,        lat:1, hold:1, exp_err:1'b1, exp_dat:32'h0};

        rst = 1'b1;
        i_m_cyc = 0; i_m_stb = 0; i_m_we = 0; i_m_sel = '0; i_m_adr = '0; i_m_dat = '0;
        i_s_dat = '0; i_s_ack = '0; i_s_int = '0;
        repeat (3) tick();
        chk("reset.ctl", 64'({o_s_cyc, o_s_stb, o_s_we, o_m_ack, o_m_err, o_m_int}), 64'd0);
        chk("reset.bus", 64'({o_s_sel, o_s_adr}), 64'd0);
        chk("reset.sdat", 64'(o_s_dat), 64'd0);
        chk("reset.mdat", 64'(o_m_dat), 64'd0);
        rst = 1'b0;
        tick();

        // Directed vector table.
        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
        end

        // Random transactions; expected result from the address-decode rule.
        for (int i = 0; i < 40; i++) begin
            rv.idx  = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 7));
            rv.off  = OW'($urandom);
            rv.we   = 1'($urandom);
            rv.sel  = SW'($urandom);
            rv.wdat = $urandom;
            rv.sdat = $urandom;
            rv.lat  = int'($urandom_range(1, 5));
            rv.hold = int'($urandom_range(0, 3));
            rv.exp_err = (rv.idx >= int'(NS));
            rv.exp_dat = rv.exp_err ? '0 : rv.sdat;
            run_txn(rv, $sformatf("rnd%0d", i));
        end

        // Abort: drop cyc two cycles into ACTIVE, then the slave acks late.
        i_m_adr = {8'd0, 24'h000100}; i_m_we = 0; i_m_sel = 4'hF;
        i_m_cyc = 1; i_m_stb = 1;
        tick();
        tick();
        chk("abort.stb_before", 64'(o_s_stb), 64'd1);
        i_m_cyc = 0; i_m_stb = 0;
        tick();
        chk("abort.stb_after", 64'(o_s_stb), 64'd0);
        i_s_ack = 4'b0001;
        n_ack = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            i_s_ack = '0;
            if (o_m_ack) n_ack++;
        end
        chk("abort.no_ack", 64'(n_ack), 64'd0);

        // Reset in the middle of ACTIVE clears every output on the next edge.
        i_m_adr = {8'd3, 24'h00ABCD}; i_m_we = 1; i_m_sel = 4'hF; i_m_dat = 32'h87654321;
        i_s_int = 4'b1000;
        i_m_cyc = 1; i_m_stb = 1;
        tick();
        tick();
        chk("rstmid.stb_before", 64'(o_s_stb), 64'h8);
        rst = 1'b1;
        tick();
        chk("rstmid.ctl", 64'({o_s_cyc, o_s_stb, o_s_we, o_m_ack, o_m_err, o_m_int}), 64'd0);
        chk("rstmid.bus", 64'({o_s_sel, o_s_adr}), 64'd0);
        chk("rstmid.sdat", 64'(o_s_dat), 64'd0);
        rst = 1'b0;
        i_m_cyc = 0; i_m_stb = 0; i_s_int = '0;
        tick();
        tick();

        // Interrupt aggregation: random patterns then the single-cycle pulse.
        for (int i = 0; i < 30; i++) begin
            prev_int = NS'($urandom);
            i_s_int = prev_int;
            tick();
            chk($sformatf("int.rnd%0d", i), 64'(o_m_int), 64'(prev_int != '0));
        end
        i_s_int = '0;
        tick();
        chk("int.idle", 64'(o_m_int), 64'd0);
        i_s_int = 4'b0100;
        tick();
        chk("int.pulse_hi", 64'(o_m_int), 64'd1);
        i_s_int = '0;
        tick();
        chk("int.pulse_lo", 64'(o_m_int), 64'd0);

        // Slave 0 never acks.
        i_m_adr = {8'd0, 24'h000040}; i_m_we = 0; i_m_sel = 4'hF;
        i_s_ack = '0;
        i_m_cyc = 1; i_m_stb = 1;
`ifdef WB_TIMEOUT_EN
        n_stb = 0; err_at = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (o_s_stb[0]) n_stb++;
            if (o_m_err && err_at < 0) begin
                err_at = c;
                chk("tmo.stb_low", 64'(o_s_stb), 64'd0);
                chk("tmo.ack", 64'(o_m_ack), 64'd1);
                chk("tmo.mdat", 64'(o_m_dat), 64'd0);
            end
        end
        chk("tmo.err_cycle", 64'(err_at), 64'(TO + 1));
        chk("tmo.n_stb", 64'(n_stb), 64'(TO));
`else
        bad = 0; err_at = 0; n_stb = 0;
        for (int c = 1; c <= 1000; c++) begin
            tick();
            if (o_m_err || o_m_ack) bad++;
            if (o_s_stb == 4'b0001) n_stb++;
        end
        chk("notmo.no_err", 64'(bad), 64'd0);
        chk("notmo.stb_held", 64'(n_stb), 64'd1000);
        chk("notmo.err_at", 64'(err_at), 64'd0);
`endif
        i_m_cyc = 0; i_m_stb = 0;
        tick();
        tick();
        chk("end.idle", 64'({o_s_stb, o_m_ack, o_m_err}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
